// File: rtl/key_repeat_pkg.sv
// Shared definitions for the key auto-repeat block.
//   ch_state_e        : per-channel FSM state
//   BTN_*             : channel index of each game button
//   DEFAULT_*_CYC     : default initial-delay and repeat-period in clk cycles
//   max_u()           : larger of two unsigned ints (used for counter sizing)
package key_repeat_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat,
        StWaitRel
    } ch_state_e;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_ROT   = 2;
    localparam int unsigned BTN_DOWN  = 3;

    localparam int unsigned DEFAULT_DELAY_CYC = 25_000_000;
    localparam int unsigned DEFAULT_RATE_CYC  = 8_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_repeat_ch.sv
// One auto-repeat channel: turns a held button level into move strobes.
// A press gives an immediate strobe; if REPEAT is set, a second strobe
// follows DELAY_CYC cycles later and then one every RATE_CYC cycles.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   en    : game-active qualifier; low forces the channel idle
//   btn   : debounced button level, synchronous to clk
//   pulse : registered single-cycle move strobe
//   held  : registered, high while the channel is not idle
module key_repeat_ch
    import key_repeat_pkg::*;
#(
    parameter int unsigned DELAY_CYC = DEFAULT_DELAY_CYC,
    parameter int unsigned RATE_CYC  = DEFAULT_RATE_CYC,
    parameter bit          REPEAT    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn,
    output logic pulse,
    output logic held
);

    localparam int unsigned CNT_W = $clog2(max_u(DELAY_CYC, RATE_CYC));
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYC - 1);

    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             held_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else if (state_q != StIdle && !btn) begin
            // Release wins over a coinciding terminal count: no strobe.
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (btn) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                        state_q <= REPEAT ? StDelay : StWaitRel;
                    end else begin
                        held_q  <= 1'b0;
                    end
                end
                StDelay: begin
                    if (cnt_q == DELAY_LAST) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StRepeat;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                StRepeat: begin
                    if (cnt_q == RATE_LAST) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                StWaitRel: begin
                    cnt_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: rtl/key_repeat.sv
// Key auto-repeat for N_BTN independent button channels.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   en    : game-active qualifier
//   btn   : [N_BTN] debounced button levels
//   pulse : [N_BTN] single-cycle move-request strobes
//   held  : [N_BTN] high while the channel is not idle
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int unsigned      N_BTN       = 4,
    parameter int unsigned      DELAY_CYC   = DEFAULT_DELAY_CYC,
    parameter int unsigned      RATE_CYC    = DEFAULT_RATE_CYC,
    parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(4'b1011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] pulse,
    output logic [N_BTN-1:0] held
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        key_repeat_ch #(
            .DELAY_CYC (DELAY_CYC),
            .RATE_CYC  (RATE_CYC),
            .REPEAT    (REPEAT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .btn   (btn[i]),
            .pulse (pulse[i]),
            .held  (held[i])
        );
    end

endmodule

// File: tb/tb_key_repeat.sv
module tb_key_repeat;

    localparam int unsigned D = 8;
    localparam int unsigned R = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] btn;
    logic [3:0] pulse;
    logic [3:0] held;
    logic [3:0] mask = 4'b1011;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: per channel, length of the current unbroken run of
    // samples with rst=0, en=1, btn=1. Strobes fall at run offsets 0, D, D+R, ...
    int         streak [4];
    logic [3:0] m_pulse;
    logic [3:0] m_held;
    int         expq [$];

    key_repeat #(
        .N_BTN       (4),
        .DELAY_CYC   (D),
        .RATE_CYC    (R),
        .REPEAT_MASK (4'b1011)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .btn   (btn),
        .pulse (pulse),
        .held  (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] b;
        logic [3:0] p;
        logic [3:0] h;
    } vec_t;

    vec_t tbl [13];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at step %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            logic act;
            int   age;
            act = !r && e && b[i];
            streak[i] = act ? streak[i] + 1 : 0;
            age = streak[i] - 1;
            m_held[i]  = act;
            m_pulse[i] = act && ((age == 0) ||
                         (mask[i] && age >= int'(D) && ((age - int'(D)) % int'(R)) == 0));
        end
    endtask

    // Drive one cycle of inputs, clock, then compare outputs to the model.
    task automatic step(input logic r, input logic e, input logic [3:0] b);
        rst = r;
        en  = e;
        btn = b;
        @(posedge clk);
        #1;
        cyc++;
        model_update(r, e, b);
        check4("model pulse", pulse, m_pulse);
        check4("model held", held, m_held);
    endtask

    task automatic idle_gap();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b0000);
    endtask

    function automatic logic in_exp(input int c);
        foreach (expq[k]) if (expq[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int         npulse;
        logic [3:0] rb;
        logic       re;
        logic       rr;

        for (int i = 0; i < 4; i++) streak[i] = 0;
        rst = 1'b1;
        en  = 1'b1;
        btn = 4'b0000;

        // Table: reset override, non-repeating rotate, 1-cycle gap, en gating.
        tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100};
        tbl[2]  = '{1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0100};
        tbl[3]  = '{1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0100};
        tbl[4]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100};
        tbl[6]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100};
        tbl[8]  = '{1'b0, 1'b0, 4'b0110, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b0, 1'b1, 4'b0110, 4'b0110, 4'b0110};
        tbl[10] = '{1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0110};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000};

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].r, tbl[k].e, tbl[k].b);
            check4("table pulse", pulse, tbl[k].p);
            check4("table held", held, tbl[k].h);
        end
        idle_gap();

        // Left held cycles 10..40: strobes at 11,19,22,...,40; held drops at 42.
        expq = '{11, 19, 22, 25, 28, 31, 34, 37, 40};
        for (int c = 0; c <= 45; c++) begin
            step(1'b0, 1'b1, {3'b000, (c >= 10 && c <= 40)});
            check4("left repeat pulse", {3'b000, pulse[0]}, {3'b000, in_exp(c + 1)});
            if (c == 40) check4("left held at 41", {3'b000, held[0]}, 4'b0001);
            if (c == 41) check4("left held at 42", {3'b000, held[0]}, 4'b0000);
        end
        idle_gap();

        // Rotate held 30 cycles: exactly one strobe, at press+1.
        npulse = 0;
        expq = '{3};
        for (int c = 0; c <= 35; c++) begin
            step(1'b0, 1'b1, {1'b0, (c >= 2 && c < 32), 2'b00});
            npulse += int'(pulse[2]);
            check4("rotate pulse", {3'b000, pulse[2]}, {3'b000, in_exp(c + 1)});
        end
        check_int("rotate pulse count", npulse, 1);
        idle_gap();

        // Right released on the cycle its count reaches D-1: no second strobe.
        npulse = 0;
        for (int c = 0; c <= 12; c++) begin
            step(1'b0, 1'b1, {2'b00, (c <= 7), 1'b0});
            npulse += int'(pulse[1]);
            if (c == 8) check4("right idle after release", {2'b00, held[1], pulse[1]}, 4'b0000);
        end
        check_int("right pulse count", npulse, 1);
        idle_gap();

        // Left and down pressed together: identical timing.
        expq = '{1, 9, 12, 15, 18, 21, 24, 27};
        for (int c = 0; c <= 30; c++) begin
            step(1'b0, 1'b1, (c <= 27) ? 4'b1001 : 4'b0000);
            check4("dual pulse", {pulse[3], 2'b00, pulse[0]},
                   {in_exp(c + 1), 2'b00, in_exp(c + 1)});
        end
        idle_gap();

        // en dropped mid-repeat, then raised with the button still held.
        expq = '{1, 9, 12, 17, 25, 28};
        for (int c = 0; c <= 29; c++) begin
            step(1'b0, !(c >= 13 && c <= 15), 4'b0001);
            check4("en gate pulse", {3'b000, pulse[0]}, {3'b000, in_exp(c + 1)});
        end
        idle_gap();

        // One-cycle reset mid-repeat with the button held.
        expq = '{1, 9, 12, 15, 23, 26};
        for (int c = 0; c <= 26; c++) begin
            step((c == 13), 1'b1, 4'b0001);
            check4("rst mid pulse", {3'b000, pulse[0]}, {3'b000, in_exp(c + 1)});
            if (c == 13) check4("rst mid held", held, 4'b0000);
        end
        idle_gap();

        // Random stimulus against the model; buttons tend to stay put.
        rb = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) rb[i] = ~rb[i];
            re = ($urandom_range(31) != 0);
            rr = ($urandom_range(63) == 0);
            step(rr, re, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 The block SHALL have the parameter N_BTN, default 4, giving the number of button channels (0=left, 1=right, 2=rotate, 3=down).
REQ-002 The block SHALL have the parameter DELAY_CYC, default 25_000_000, giving the number of cycles between the first pulse and the first repeat pulse; legal values are 2 or more.
REQ-003 The block SHALL have the parameter RATE_CYC, default 8_000_000, giving the number of cycles between successive repeat pulses; legal values are 2 or more.
REQ-004 The block SHALL have the parameter REPEAT_MASK, default 4'b1011, where bit i=1 enables auto-repeat on channel i (rotate does not repeat).
REQ-005 The block SHALL have the port clk, input, 1 bit: the system clock.
REQ-006 The block SHALL have the port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-007 The block SHALL have the port en, input, 1 bit: game-active qualifier.
REQ-008 The block SHALL have the port btn, input, N_BTN bits: debounced button levels, already synchronous to clk.
REQ-009 The block SHALL have the port pulse, output, N_BTN bits: single-cycle move-request strobes.
REQ-010 The block SHALL have the port held, output, N_BTN bits: high while the channel is not IDLE.

Function
REQ-011 Each channel SHALL run an independent FSM with the states IDLE, DELAY, REPEAT and WAIT_REL, plus a counter of width $clog2(max(DELAY_CYC,RATE_CYC)).
REQ-012 In IDLE with btn[i]=1 and en=1, the channel SHALL assert pulse[i] on the next cycle and clear cnt; it SHALL then go to DELAY if REPEAT_MASK[i]=1, otherwise to WAIT_REL.
REQ-013 In DELAY, cnt SHALL increment each cycle; at cnt==DELAY_CYC-1 the channel SHALL assert pulse[i] for one cycle, clear cnt and go to REPEAT.
REQ-014 In REPEAT, at cnt==RATE_CYC-1 the channel SHALL assert pulse[i] for one cycle and clear cnt, staying in REPEAT.
REQ-015 In DELAY, REPEAT or WAIT_REL, btn[i]=0 SHALL return the channel to IDLE on the next cycle with cnt cleared, and no pulse SHALL be emitted that cycle, even if the terminal count coincides.
REQ-016 Pulse latency SHALL be exactly 1 cycle from the first cycle btn[i]=1 is sampled in IDLE; the pulse output is registered.
REQ-017 A one-cycle btn low gap SHALL count as a release followed by a fresh press, so a new immediate pulse follows.
REQ-018 en=0 SHALL force every channel to IDLE and all pulse bits to 0 on the next cycle.
REQ-019 A button held while en rises SHALL be treated as a new press, producing a pulse 1 cycle after en=1 is sampled.
REQ-020 Channels SHALL be fully independent: simultaneous presses SHALL produce simultaneous pulses, with no priority between channels.
REQ-021 held[i] SHALL be a registered decode of state!=IDLE.

Reset
REQ-022 While rst=1, all channels SHALL be in IDLE, with cnt=0, pulse=0 and held=0, taking effect on the next clk edge.
REQ-023 rst SHALL override en and btn.
REQ-024 An rst mid-hold SHALL require btn to be sampled high in IDLE again before any pulse is produced.

Structure
REQ-025 A shared package SHALL hold the channel state enum, the channel index constants (BTN_LEFT, BTN_RIGHT, BTN_ROT, BTN_DOWN) and the default DELAY_CYC and RATE_CYC values.
REQ-026 The per-channel FSM and counter SHALL be the sub-module key_repeat_ch, instantiated N_BTN times with a generate loop; the top level adds no logic beyond wiring.

Verification (DELAY_CYC=8, RATE_CYC=3, en=1 unless stated)
REQ-027 The bench SHALL cover: btn[0] high at cycle 10, held through cycle 40 -> pulse[0] at cycles 11, 19, 22, 25, 28, ..., 40; no pulse after release; held[0] falls at cycle 42.
REQ-028 The bench SHALL cover: btn[2] held for 30 cycles -> exactly one pulse[2], 1 cycle after the press.
REQ-029 The bench SHALL cover: btn[1] released on the cycle its cnt reaches DELAY_CYC-1 -> no second pulse, and the channel is back in IDLE on the next cycle.
REQ-030 The bench SHALL cover: btn[0] and btn[3] pressed on the same cycle -> pulse[0] and pulse[3] asserted together with identical repeat timing.
REQ-031 The bench SHALL cover: en dropped during REPEAT -> pulse=0 from the next cycle; en raised with btn still high -> one immediate pulse, then the repeat restarts after 8 cycles.
REQ-032 The bench SHALL cover: rst asserted for 1 cycle mid-REPEAT with btn held -> pulse=0 and held=0 after the edge, then a fresh pulse 1 cycle after rst deasserts.
